// File: rtl/ysyx_24090003_mem_arbiter.sv
// ysyx_24090003_mem_arbiter
// Shares the core's single memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction is latched, issued on the memory port with
// a req/gnt handshake, and its response is returned to the owner as a
// registered one-cycle pulse. LSU has fixed priority over IFU. A cycle counter
// aborts transactions that spend too long in ISSUE+WAIT.
module ysyx_24090003_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            cpu_clk,
  input  logic            cpu_rs,
  // instruction fetch channel
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_resp_data,
  // load/store channel
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_resp_data,
  // memory port
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last counter value at which the transaction may still complete.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  // Counter saturates here so it can never wrap back below LIMIT.
  localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic            owner_lsu;
  logic [CW-1:0]   cnt;

  logic            in_idle;
  logic            accept_lsu;
  logic            accept_ifu;
  logic            at_limit;
  logic            finish;
  logic            abort;
  logic [DW-1:0]   resp_val;
  logic [CW-1:0]   cnt_inc;

  // Readiness is only offered in IDLE and is forced low while reset is held,
  // so every output reads 0 during reset.
  assign in_idle       = (state == IDLE);
  assign lsu_req_ready = in_idle & cpu_rs;
  assign ifu_req_ready = in_idle & cpu_rs & ~lsu_req_valid;

  assign accept_lsu = lsu_req_valid & lsu_req_ready;
  assign accept_ifu = ifu_req_valid & ifu_req_ready;

  assign at_limit = (cnt >= LIMIT);
  assign cnt_inc  = (cnt == CMAX) ? cnt : cnt + CW'(1);

  // Decide whether the in-flight transaction ends this cycle; a grant or a
  // response arriving on the limit cycle takes precedence over the abort.
  always_comb begin
    finish = 1'b0;
    abort  = 1'b0;
    case (state)
      ISSUE: begin
        abort  = ~mem_gnt & at_limit;
        finish = abort;
      end
      WAIT: begin
        abort  = ~mem_rvalid & at_limit;
        finish = mem_rvalid | at_limit;
      end
      default: begin
        finish = 1'b0;
        abort  = 1'b0;
      end
    endcase
  end

  // Stores and aborted transactions return zero data to the owner.
  assign resp_val = (abort | mem_wen) ? '0 : mem_rdata;

  // Arbiter FSM with registered memory-port fields and response pulses.
  always_ff @(posedge cpu_clk or negedge cpu_rs) begin
    if (!cpu_rs) begin
      state          <= IDLE;
      owner_lsu      <= 1'b0;
      cnt            <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_data  <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= '0;
      timeout_err    <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      timeout_err    <= abort;

      if (finish) begin
        if (owner_lsu) begin
          lsu_resp_valid <= 1'b1;
          lsu_resp_data  <= resp_val;
        end else begin
          ifu_resp_valid <= 1'b1;
          ifu_resp_data  <= resp_val;
        end
      end

      case (state)
        IDLE: begin
          if (accept_lsu) begin
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
            owner_lsu <= 1'b1;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= ISSUE;
          end else if (accept_ifu) begin
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            owner_lsu <= 1'b0;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt_inc;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end else if (abort) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (finish) begin
            state <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// Testbench for ysyx_24090003_mem_arbiter: directed scenarios plus randomized
// transactions, checked against a transaction-level timing/data model.
module tb_ysyx_24090003_mem_arbiter;

  localparam int T = 8;

  logic        cpu_clk;
  logic        cpu_rs;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  // Request valids the next transaction presents in IDLE.
  bit          req_ifu;
  bit          req_lsu;
  // Model of the last response data delivered to each requester.
  logic [31:0] last_ifu;
  logic [31:0] last_lsu;

  ysyx_24090003_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
    .cpu_clk(cpu_clk), .cpu_rs(cpu_rs),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // One transaction. The memory grants in ISSUE cycle g_dly+1 and responds
  // r_dly cycles later; the model derives the response cycle, data and
  // timeout from that arithmetic. pre=1 means the request was already
  // accepted on the upcoming edge; keep_ifu leaves the IFU request pending.
  task automatic run_txn(input bit pre, input bit keep_ifu, input int g_dly,
                         input int r_dly, input logic [31:0] rd);
    bit          own_lsu;
    bit          tmo;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_wen;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    logic [31:0] rd_seen;
    bit          exp_req;
    logic [2:0]  exp_pulse;
    logic [1:0]  exp_rdy;
    int          g;
    int          total;
    int          r_cyc;
    if (!pre) begin
      @(negedge cpu_clk);
      ifu_req_valid = req_ifu;
      lsu_req_valid = req_lsu;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b1 || ifu_req_ready !== !req_lsu) begin
        errors++;
        $display("FAIL idle_ready: got lsu=%b ifu=%b want lsu=1 ifu=%b",
                 lsu_req_ready, ifu_req_ready, !req_lsu);
      end
    end
    own_lsu = lsu_req_valid;
    if (own_lsu) begin
      e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_mask = lsu_wmask;
    end else begin
      e_addr = ifu_addr; e_wen = 1'b0; e_wdata = '0; e_mask = '0;
    end
    g     = g_dly + 1;
    total = g + r_dly;
    tmo   = (total > T);
    r_cyc = tmo ? T + 1 : total + 1;
    rd_seen = '0;

    @(posedge cpu_clk);
    #1;
    // Scramble request inputs: the in-flight transaction must not follow them.
    lsu_req_valid = 1'b0;
    lsu_addr  = $urandom;
    lsu_wdata = $urandom;
    lsu_wen   = 1'($urandom);
    lsu_wmask = 4'($urandom);
    if (!keep_ifu) begin
      ifu_req_valid = 1'b0;
      ifu_addr = $urandom;
    end

    for (int c = 1; c <= r_cyc; c++) begin
      @(negedge cpu_clk);
      exp_req = (c <= g) && (c < r_cyc);
      checks++;
      if (mem_req !== exp_req) begin
        errors++;
        $display("FAIL mem_req cycle %0d: got %b want %b", c, mem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (mem_addr !== e_addr || mem_wen !== e_wen || mem_wdata !== e_wdata ||
            mem_wmask !== e_mask) begin
          errors++;
          $display("FAIL mem_fields cycle %0d: got %h/%b/%h/%h want %h/%b/%h/%h", c,
                   mem_addr, mem_wen, mem_wdata, mem_wmask, e_addr, e_wen, e_wdata, e_mask);
        end
      end
      exp_pulse = {(c == r_cyc) && !own_lsu, (c == r_cyc) && own_lsu, (c == r_cyc) && tmo};
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid, timeout_err} !== exp_pulse) begin
        errors++;
        $display("FAIL pulses cycle %0d: got ifu/lsu/err=%b want %b", c,
                 {ifu_resp_valid, lsu_resp_valid, timeout_err}, exp_pulse);
      end
      exp_rdy = {(c == r_cyc), (c == r_cyc) && !lsu_req_valid};
      checks++;
      if ({lsu_req_ready, ifu_req_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL ready cycle %0d: got lsu/ifu=%b want %b", c,
                 {lsu_req_ready, ifu_req_ready}, exp_rdy);
      end
      if (c == r_cyc) begin
        e_data = (tmo || e_wen) ? 32'h0 : rd_seen;
        if (own_lsu) last_lsu = e_data;
        else         last_ifu = e_data;
        checks++;
        if (ifu_resp_data !== last_ifu || lsu_resp_data !== last_lsu) begin
          errors++;
          $display("FAIL resp_data: got ifu=%h lsu=%h want ifu=%h lsu=%h",
                   ifu_resp_data, lsu_resp_data, last_ifu, last_lsu);
        end
      end
      // Memory stimulus for this cycle, with stray rvalid in ISSUE and stray
      // gnt in WAIT that the arbiter must ignore.
      mem_gnt    = (c < r_cyc) && ((c == g) || (c > g && $urandom_range(0, 3) == 0));
      mem_rvalid = (c < r_cyc) && ((c == total) || (c < g && $urandom_range(0, 3) == 0));
      mem_rdata  = $urandom;
      if (c == total) begin
        mem_rdata = rd;
        rd_seen   = rd;
      end
    end
  endtask

  task automatic test_reset;
    cpu_rs = 1'b1;
    #2 cpu_rs = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 32'h1234_5678; lsu_addr = 32'h9abc_def0;
    lsu_wen = 1'b1; lsu_wdata = 32'h5555_aaaa; lsu_wmask = 4'hf;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hffff_ffff;
    repeat (2) @(negedge cpu_clk);
    checks++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req, mem_wen,
         timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {ifu_req_ready, lsu_req_ready,
               ifu_resp_valid, lsu_resp_valid, mem_req, mem_wen, timeout_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wmask, ifu_resp_data, lsu_resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h mask=%h ifu=%h lsu=%h want 0",
               mem_addr, mem_wdata, mem_wmask, ifu_resp_data, lsu_resp_data);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    last_ifu = '0; last_lsu = '0;
    @(negedge cpu_clk);
    cpu_rs = 1'b1;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got lsu=%b ifu=%b want 1 1", lsu_req_ready, ifu_req_ready);
    end
  endtask

  task automatic test_ifu_fetch;
    req_ifu = 1'b1; req_lsu = 1'b0;
    ifu_addr = 32'h8000_0000;
    run_txn(1'b0, 1'b0, 0, 1, 32'h0000_0413);
  endtask

  task automatic test_priority;
    req_ifu = 1'b1; req_lsu = 1'b1;
    ifu_addr = 32'h8000_0100;
    lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    run_txn(1'b0, 1'b1, 1, 2, 32'hcafe_0001);
    req_lsu = 1'b0;
    run_txn(1'b1, 1'b0, 0, 1, 32'hcafe_0002);
  endtask

  task automatic test_store_delayed_gnt;
    req_ifu = 1'b0; req_lsu = 1'b1;
    lsu_addr = 32'h8000_0010; lsu_wen = 1'b1;
    lsu_wdata = 32'hdead_beef; lsu_wmask = 4'hf;
    run_txn(1'b0, 1'b0, 4, 2, 32'h1111_2222);
  endtask

  task automatic test_timeout;
    req_ifu = 1'b1; req_lsu = 1'b0;
    ifu_addr = 32'h8000_0040;
    run_txn(1'b0, 1'b0, 20, 1, 32'h0);
    ifu_addr = 32'h8000_0044;
    run_txn(1'b0, 1'b0, 3, 4, 32'h7777_8888);
    req_ifu = 1'b0; req_lsu = 1'b1;
    lsu_addr = 32'h8000_0048; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    run_txn(1'b0, 1'b0, 4, 4, 32'h9999_aaaa);
  endtask

  task automatic test_stray_rvalid;
    req_ifu = 1'b0; req_lsu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      mem_rvalid = 1'b1;
      mem_gnt    = 1'($urandom);
      mem_rdata  = $urandom;
      #1;
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid, mem_req, timeout_err, lsu_req_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL stray_idle %0d: got ifu/lsu/req/err/rdy=%b want 00001", i,
                 {ifu_resp_valid, lsu_resp_valid, mem_req, timeout_err, lsu_req_ready});
      end
    end
    @(negedge cpu_clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    req_ifu = 1'b1;
    ifu_addr = 32'h8000_0080;
    run_txn(1'b0, 1'b0, 0, 2, 32'h0bad_f00d);
  endtask

  task automatic test_reset_in_wait;
    @(negedge cpu_clk);
    lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    lsu_req_valid = 1'b1;
    @(posedge cpu_clk);
    #1 lsu_req_valid = 1'b0;
    @(negedge cpu_clk);
    mem_gnt = 1'b1;
    @(negedge cpu_clk);
    mem_gnt = 1'b0;
    cpu_rs  = 1'b0;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req, timeout_err,
         mem_wen} !== 7'b0 || {mem_addr, mem_wdata, mem_wmask, ifu_resp_data, lsu_resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ctrl=%b addr=%h lsu_data=%h ifu_data=%h want all 0",
               {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req,
                timeout_err, mem_wen}, mem_addr, lsu_resp_data, ifu_resp_data);
    end
    last_ifu = '0; last_lsu = '0;
    @(negedge cpu_clk);
    cpu_rs = 1'b1;
    @(negedge cpu_clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9bdf;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      mem_rvalid = 1'b0;
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid, mem_req, timeout_err, lsu_req_ready} !== 5'b00001 ||
          lsu_resp_data !== 32'h0) begin
        errors++;
        $display("FAIL after_reset_rvalid %0d: got ifu/lsu/req/err/rdy=%b data=%h want 00001 0", i,
                 {ifu_resp_valid, lsu_resp_valid, mem_req, timeout_err, lsu_req_ready}, lsu_resp_data);
      end
    end
  endtask

  task automatic test_random;
    int kind;
    int g_dly;
    int r_dly;
    for (int i = 0; i < 30; i++) begin
      kind  = $urandom_range(0, 2);
      g_dly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
      r_dly = $urandom_range(1, 4);
      ifu_addr = $urandom;
      lsu_addr = $urandom; lsu_wen = 1'($urandom);
      lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      req_ifu = (kind != 1);
      req_lsu = (kind != 0);
      run_txn(1'b0, kind == 2, g_dly, r_dly, $urandom);
      if (kind == 2) begin
        req_lsu = 1'b0;
        run_txn(1'b1, 1'b0, $urandom_range(0, 5), $urandom_range(1, 4), $urandom);
      end
    end
  endtask

  initial begin
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    req_ifu = 1'b0; req_lsu = 1'b0;
    last_ifu = '0; last_lsu = '0;
    test_reset();
    test_ifu_fetch();
    test_priority();
    test_store_delayed_gnt();
    test_timeout();
    test_stray_rvalid();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
